// File: rtl/sort_pkg.sv
// Constants and FSM state type shared by the bubble-sort datapath blocks.
package sort_pkg;

    localparam int N_ELEM = 10;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } stream_state_e;

endpackage

// File: rtl/sort_stream_out_rise_detect.sv
// Turns a level-style completion flag into a single-cycle rise strobe.
module rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;

    // Resetting to 0 makes a flag already high at reset release count as a rise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/sort_stream_out.sv
// Captures the sorter's parallel result and streams it out over valid/ready,
// flagging any element smaller than its predecessor.
module sort_stream_out #(
    parameter int N_ELEM = sort_pkg::N_ELEM,
    parameter int DATA_W = sort_pkg::DATA_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     sort_done_i,
    input  logic [N_ELEM*DATA_W-1:0] array_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     order_err_o
);

    import sort_pkg::*;

    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    stream_state_e     state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] elem_buf [N_ELEM];
    logic              rise;

    rise_detect u_rise_detect (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .level_i (sort_done_i),
        .rise_o  (rise)
    );

    assign idx_next = idx + IDX_W'(1);

    // Outputs are loaded one element ahead so nothing depends combinationally on ready_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            idx         <= '0;
            prev        <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            last_o      <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            order_err_o <= 1'b0;
            for (int k = 0; k < N_ELEM; k++) begin
                elem_buf[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        for (int k = 0; k < N_ELEM; k++) begin
                            elem_buf[k] <= array_i[k*DATA_W +: DATA_W];
                        end
                        idx         <= '0;
                        prev        <= '0;
                        order_err_o <= 1'b0;
                        data_o      <= array_i[0 +: DATA_W];
                        valid_o     <= 1'b1;
                        last_o      <= (LAST_IDX == '0);
                        busy_o      <= 1'b1;
                        state       <= STREAM;
                    end
                end
                STREAM: begin
                    if (ready_i) begin
                        if ((idx != '0) && (elem_buf[idx] < prev)) begin
                            order_err_o <= 1'b1;
                        end
                        prev <= elem_buf[idx];
                        if (idx == LAST_IDX) begin
                            data_o  <= '0;
                            valid_o <= 1'b0;
                            last_o  <= 1'b0;
                            done_o  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            idx    <= idx_next;
                            data_o <= elem_buf[idx_next];
                            last_o <= (idx_next == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    data_o  <= '0;
                    valid_o <= 1'b0;
                    last_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_stream_out.sv
// Self-checking bench for sort_stream_out: table-driven streams plus reset,
// held-flag and ignored-rise sequences, checked against a simple array model.
module tb_sort_stream_out;

    localparam int N      = 10;
    localparam int W      = 4;
    localparam int BUDGET = 200;

    logic           clk;
    logic           rst_ni;
    logic           sort_done_i;
    logic [N*W-1:0] array_i;
    logic [W-1:0]   data_o;
    logic           valid_o;
    logic           ready_i;
    logic           last_o;
    logic           busy_o;
    logic           done_o;
    logic           order_err_o;

    int nchecks = 0;
    int nfail   = 0;

    // mode: 0 ready high, 1 ready 1,0,0,1 pattern, 2 random ready,
    // 3 ready high with a rise and new array mid-stream, 4 ready high and flag dropped early
    typedef struct {
        logic [N*W-1:0] arr;
        int             mode;
        bit             exp_err;
    } vec_t;

    vec_t vecs[7];

    sort_stream_out #(
        .N_ELEM (N),
        .DATA_W (W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .sort_done_i (sort_done_i),
        .array_i     (array_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .order_err_o (order_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: element k of a packed array, and whether any of the
    // first n elements is smaller than the one before it.
    function automatic logic [W-1:0] expElem(input logic [N*W-1:0] a, input int k);
        return a[k*W +: W];
    endfunction

    function automatic bit errUpTo(input logic [N*W-1:0] a, input int n);
        for (int k = 1; k < n; k++) begin
            if (a[k*W +: W] < a[(k-1)*W +: W]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nfail++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Arrange for a rise of sort_done_i to be sampled on the next clock edge
    // seen by streamBody; drops the flag for one cycle first if it is high.
    task automatic applyStimulus(input logic [N*W-1:0] arr);
        if (sort_done_i) begin
            @(posedge clk); #1;
            sort_done_i = 1'b0;
            array_i     = arr;
            @(posedge clk); #1;
            sort_done_i = 1'b1;
        end else begin
            array_i     = arr;
            sort_done_i = 1'b1;
        end
    endtask

    task automatic streamBody(input logic [N*W-1:0] arr, input int mode, input bit final_err);
        int           beat;
        int           cyc;
        bit           stalled;
        logic [W-1:0] held;
        beat    = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (beat < N && cyc < BUDGET) begin
            @(posedge clk); #1;
            case (mode)
                1:       ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2:       ready_i = 1'($urandom_range(0, 1));
                default: ready_i = 1'b1;
            endcase
            if (mode == 3 && cyc == 2) sort_done_i = 1'b0;
            if (mode == 3 && cyc == 3) begin
                sort_done_i = 1'b1;
                array_i     = ~arr;
            end
            if (mode == 4 && cyc == 1) sort_done_i = 1'b0;
            @(negedge clk);
            if (cyc == 0) checkOutput("capture_latency", int'(valid_o), 1);
            if (stalled) begin
                checkOutput("stall_valid", int'(valid_o), 1);
                checkOutput("stall_data", int'(data_o), int'(held));
            end
            if (valid_o) begin
                checkOutput("last_flag", int'(last_o), int'(beat == N-1));
                checkOutput("busy_stream", int'(busy_o), 1);
                checkOutput("order_err_live", int'(order_err_o), int'(errUpTo(arr, beat)));
                if (ready_i) begin
                    checkOutput("beat_data", int'(data_o), int'(expElem(arr, beat)));
                    beat++;
                end
            end
            stalled = valid_o && !ready_i;
            held    = data_o;
            cyc++;
        end
        if (beat < N) begin
            nchecks++;
            nfail++;
            $display("[TB] FAIL stream_timeout beats=%0d required=%0d", beat, N);
        end
        @(posedge clk); #1;
        ready_i = 1'b0;
        @(negedge clk);
        checkOutput("done_pulse", int'(done_o), 1);
        checkOutput("done_valid", int'(valid_o), 0);
        checkOutput("done_busy", int'(busy_o), 1);
        checkOutput("done_order_err", int'(order_err_o), int'(final_err));
        @(negedge clk);
        checkOutput("idle_done", int'(done_o), 0);
        checkOutput("idle_busy", int'(busy_o), 0);
        checkOutput("idle_valid", int'(valid_o), 0);
        checkOutput("idle_order_err", int'(order_err_o), int'(final_err));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int             q[$];
        logic [N*W-1:0] tmp;

        vecs[0] = '{40'h9876543210, 0, 1'b0};
        vecs[1] = '{40'h9876543210, 1, 1'b0};
        vecs[2] = '{40'h9987635221, 4, 1'b1};
        vecs[3] = '{40'hFFFFFFFFFF, 0, 1'b0};
        for (int i = 0; i < N; i++) q.push_back(int'($urandom_range(0, 15)));
        q.sort();
        tmp = '0;
        for (int i = 0; i < N; i++) tmp[i*W +: W] = W'(q[i]);
        vecs[4] = '{tmp, 2, 1'b0};
        tmp = {8'($urandom), $urandom};
        vecs[5] = '{tmp, 2, errUpTo(tmp, N)};
        vecs[6] = '{40'h9876543210, 3, 1'b0};

        rst_ni      = 1'b0;
        sort_done_i = 1'b0;
        ready_i     = 1'b0;
        array_i     = '0;
        #12;
        checkOutput("reset_valid", int'(valid_o), 0);
        checkOutput("reset_data", int'(data_o), 0);
        checkOutput("reset_last", int'(last_o), 0);
        checkOutput("reset_busy", int'(busy_o), 0);
        checkOutput("reset_done", int'(done_o), 0);
        checkOutput("reset_order_err", int'(order_err_o), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            $display("[TB] vector %0d mode %0d array %h", i, vecs[i].mode, vecs[i].arr);
            applyStimulus(vecs[i].arr);
            streamBody(vecs[i].arr, vecs[i].mode, vecs[i].exp_err);
        end

        // Flag still held high after the last stream: no recapture may happen.
        repeat (6) begin
            @(negedge clk);
            checkOutput("held_no_restream", int'(valid_o), 0);
        end

        // Abort mid-stream with reset; flag stays high so release counts as a rise.
        applyStimulus(40'h9876543210);
        ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        checkOutput("pre_reset_data", int'(data_o), 4);
        rst_ni = 1'b0;
        #1;
        checkOutput("abort_valid", int'(valid_o), 0);
        checkOutput("abort_busy", int'(busy_o), 0);
        checkOutput("abort_data", int'(data_o), 0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort_no_done", int'(done_o), 0);
        end
        rst_ni  = 1'b1;
        ready_i = 1'b0;
        streamBody(40'h9876543210, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
